// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store sequencer between the execute stage and a word-wide, handshaked
// data memory port. One access is in flight at a time. An access that crosses
// a word boundary is issued as two word-aligned beats, and the returned words
// are merged. Loads return a sign- or zero-extended result.
//
// mem_ctrl encoding: [1:0] 00 = byte, 01 = half, 10/11 = word; [2] 1 = unsigned.
//
// Optional build macro:
//   LSU_MISALIGN_TRAP_EN - a word-crossing access performs no memory beat. It
//                          completes one cycle after the request, with
//                          cpu_fault set.
//
// Parameters:
//   ADDR_W   - address width in bits
//   MAX_WAIT - cycles without progress before the access is aborted (0 = never)
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/mem_ctrl - request fields, sampled only when idle
//   cpu_stall           - high while an access is in flight (combinational
//                         from cpu_req when idle)
//   cpu_done/cpu_fault  - one-cycle completion pulse / error flag
//   cpu_rdata           - formatted load result, held until the next completion
//   mem_valid/ready/we/addr/be/wdata - beat request channel
//   mem_rvalid/rdata    - in-order read return channel
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [2:0]        cpu_mem_ctrl,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int WAIT_W = 16;
    localparam bit TMO_EN = (MAX_WAIT > 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_W0   = 3'd2,
        S_B1   = 3'd3,
        S_W1   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Lane mask for an access size, before shifting by the byte offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            2'b00:   lane_mask = 4'b0001;
            2'b01:   lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Shift the merged {hi,lo} pair down by the offset and extend to 32 bits.
    function automatic logic [31:0] fmt_load(input logic [63:0] raw,
                                             input logic [2:0]  ctrl,
                                             input logic [1:0]  off);
        logic [31:0] sh;
        sh = 32'(raw >> {off, 3'b000});
        case (ctrl[1:0])
            2'b00:   fmt_load = ctrl[2] ? {24'h000000, sh[7:0]}
                                        : {{24{sh[7]}}, sh[7:0]};
            2'b01:   fmt_load = ctrl[2] ? {16'h0000, sh[15:0]}
                                        : {{16{sh[15]}}, sh[15:0]};
            default: fmt_load = sh;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [31:0]         lo_q, lo_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [2:0]          ctrl_q, ctrl_d;
    logic                fault_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                cpu_done_q, cpu_fault_q;

    // While idle the live request fields drive the decode so that the beat
    // outputs can be registered on the same edge that accepts the request.
    logic                idle_s;
    logic                src_we_s;
    logic [ADDR_W-1:0]   src_addr_s;
    logic [31:0]         src_wdata_s;
    logic [2:0]          src_ctrl_s;
    logic [1:0]          off_s;
    logic [7:0]          lanes_s;
    logic                split_s;
    logic [63:0]         wsh_s;
    logic [ADDR_W-1:0]   word_addr_s;
    logic [ADDR_W-1:0]   next_addr_s;
    logic                timeout_s;

    assign idle_s      = (state_q == S_IDLE);
    assign src_we_s    = idle_s ? cpu_we       : we_q;
    assign src_addr_s  = idle_s ? cpu_addr     : addr_q;
    assign src_wdata_s = idle_s ? cpu_wdata    : wdata_q;
    assign src_ctrl_s  = idle_s ? cpu_mem_ctrl : ctrl_q;

    assign off_s       = src_addr_s[1:0];
    // Lanes [3:0] belong to the first word, [7:4] spill into the next one.
    assign lanes_s     = {4'b0000, lane_mask(src_ctrl_s[1:0])} << off_s;
    assign split_s     = |lanes_s[7:4];
    assign wsh_s       = {32'h00000000, src_wdata_s} << {off_s, 3'b000};
    assign word_addr_s = {src_addr_s[ADDR_W-1:2], 2'b00};
    assign next_addr_s = word_addr_s + ADDR_W'(4);
    assign timeout_s   = TMO_EN && (wait_q == WAIT_W'(MAX_WAIT - 1));

    // Next-state, wait counter, request latch and load-result computation.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        lo_d    = lo_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    ctrl_d  = cpu_mem_ctrl;
                    if (TRAP_EN && split_s) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_B0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_B0, S_B1: begin
                if (mem_ready) begin
                    wait_d = '0;
                    if (!we_q) begin
                        state_d = (state_q == S_B0) ? S_W0 : S_W1;
                    end else if ((state_q == S_B0) && split_s) begin
                        state_d = S_B1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timeout_s) begin
                    wait_d  = '0;
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_W0: begin
                if (mem_rvalid) begin
                    wait_d = '0;
                    lo_d   = mem_rdata;
                    if (split_s) begin
                        state_d = S_B1;
                    end else begin
                        state_d = S_DONE;
                        rdata_d = fmt_load({32'h00000000, mem_rdata}, ctrl_q, addr_q[1:0]);
                    end
                end else if (timeout_s) begin
                    wait_d  = '0;
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_W1: begin
                if (mem_rvalid) begin
                    wait_d  = '0;
                    state_d = S_DONE;
                    rdata_d = fmt_load({mem_rdata, lo_q}, ctrl_q, addr_q[1:0]);
                end else if (timeout_s) begin
                    wait_d  = '0;
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DONE: begin
                wait_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                wait_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Beat outputs for the cycle after this edge, derived from the next state.
    always_comb begin
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_be_d    = 4'b0000;
        mem_wdata_d = 32'h00000000;
        case (state_d)
            S_B0: begin
                mem_valid_d = 1'b1;
                mem_we_d    = src_we_s;
                mem_addr_d  = word_addr_s;
                mem_be_d    = lanes_s[3:0];
                mem_wdata_d = src_we_s ? wsh_s[31:0] : 32'h00000000;
            end
            S_B1: begin
                mem_valid_d = 1'b1;
                mem_we_d    = src_we_s;
                mem_addr_d  = next_addr_s;
                mem_be_d    = lanes_s[7:4];
                mem_wdata_d = src_we_s ? wsh_s[63:32] : 32'h00000000;
            end
            default: begin
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // Control state, captured request and merge buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            lo_q    <= 32'h00000000;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h00000000;
            ctrl_q  <= 3'b000;
            rdata_q <= 32'h00000000;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
        end
    end

    // Registered memory-port and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h00000000;
            cpu_done_q  <= 1'b0;
            cpu_fault_q <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_done_q  <= (state_d == S_DONE);
            cpu_fault_q <= fault_d;
        end
    end

    assign cpu_stall = !idle_s || cpu_req;
    assign cpu_done  = cpu_done_q;
    assign cpu_fault = cpu_fault_q;
    assign cpu_rdata = rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for lsu_mem_ctrl (ADDR_W = 32, MAX_WAIT = 15).
// A small word memory answers beats; every accepted beat is logged so that
// addresses, byte enables and write data can be compared against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_mem_ctrl;
    logic        cpu_stall;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_fault;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [0:255];
    logic        pending;
    logic [31:0] pend_data;
    logic        rv_block;
    logic        rv_inject;

    logic [31:0] lg_addr[$];
    logic [31:0] lg_be[$];
    logic [31:0] lg_wdata[$];
    logic [31:0] lg_we[$];

    lsu_mem_ctrl #(.ADDR_W(32), .MAX_WAIT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_mem_ctrl (cpu_mem_ctrl),
        .cpu_stall    (cpu_stall),
        .cpu_done     (cpu_done),
        .cpu_rdata    (cpu_rdata),
        .cpu_fault    (cpu_fault),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: logs accepted beats, returns read data one cycle later.
    initial begin
        pending    = 1'b0;
        pend_data  = 32'h0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            mem_rvalid = rv_inject | (pending & ~rv_block);
            mem_rdata  = rv_inject ? 32'hDEAD0000 : pend_data;
            if (rst_n && mem_valid && mem_ready) begin
                lg_addr.push_back(mem_addr);
                lg_be.push_back({28'h0, mem_be});
                lg_wdata.push_back(mem_wdata);
                lg_we.push_back({31'h0, mem_we});
                pending   = !mem_we;
                pend_data = mem_arr[mem_addr[9:2]];
            end else begin
                pending = 1'b0;
            end
        end
    end

    // Issue one request at the current negedge and wait for cpu_done.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] ctrl, input int budget, output int cyc);
        lg_addr.delete();
        lg_be.delete();
        lg_wdata.delete();
        lg_we.delete();
        cpu_req      = 1'b1;
        cpu_we       = we;
        cpu_addr     = addr;
        cpu_wdata    = wdata;
        cpu_mem_ctrl = ctrl;
        #1;
        chk("stall_on_req", {31'h0, cpu_stall}, 32'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cpu_req = 1'b0;
            cyc++;
        end while (!cpu_done && cyc < budget);
        chk("done_seen", {31'h0, cpu_done}, 32'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc;
        int vcnt;
        rst_n        = 1'b0;
        cpu_req      = 1'b0;
        cpu_we       = 1'b0;
        cpu_addr     = 32'h0;
        cpu_wdata    = 32'h0;
        cpu_mem_ctrl = 3'b000;
        mem_ready    = 1'b1;
        rv_block     = 1'b0;
        rv_inject    = 1'b0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[8'h80] = 32'hAA000000;
        mem_arr[8'h81] = 32'h00CCBBDD;
        mem_arr[8'hFF] = 32'h55667788;
        mem_arr[8'h00] = 32'h11223344;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'h0, cpu_stall}, 32'd0);
        chk("rst_done",  {31'h0, cpu_done},  32'd0);
        chk("rst_fault", {31'h0, cpu_fault}, 32'd0);
        chk("rst_valid", {31'h0, mem_valid}, 32'd0);
        chk("rst_we",    {31'h0, mem_we},    32'd0);
        chk("rst_be",    {28'h0, mem_be},    32'd0);
        chk("rst_addr",  mem_addr,           32'd0);
        chk("rst_wdata", mem_wdata,          32'd0);
        chk("rst_rdata", cpu_rdata,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned signed byte load
        mem_arr[8'h40] = 32'h11803344;
        do_access(1'b0, 32'h102, 32'h0, 3'b000, 20, cyc);
        chk("t1_cyc",   cyc, 32'd3);
        chk("t1_rdata", cpu_rdata, 32'hFFFFFF80);
        chk("t1_fault", {31'h0, cpu_fault}, 32'd0);
        chk("t1_nbeat", lg_addr.size(), 32'd1);
        chk("t1_addr",  lg_addr[0], 32'h100);
        chk("t1_be",    lg_be[0], 32'b0100);
        @(negedge clk);
        chk("t1_pulse", {31'h0, cpu_done}, 32'd0);
        chk("t1_idle",  {31'h0, cpu_stall}, 32'd0);

        // Unsigned half load
        mem_arr[8'h40] = 32'hBEEF1234;
        do_access(1'b0, 32'h102, 32'h0, 3'b101, 20, cyc);
        chk("t2_cyc",   cyc, 32'd3);
        chk("t2_rdata", cpu_rdata, 32'h0000BEEF);
        chk("t2_be",    lg_be[0], 32'b1100);
        @(negedge clk);

        // Word-crossing word load
        do_access(1'b0, 32'h203, 32'h0, 3'b010, 20, cyc);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("t3_cyc",   cyc, 32'd1);
        chk("t3_nbeat", lg_addr.size(), 32'd0);
        chk("t3_fault", {31'h0, cpu_fault}, 32'd1);
        chk("t3_rdata", cpu_rdata, 32'h0000BEEF);
`else
        chk("t3_cyc",   cyc, 32'd5);
        chk("t3_nbeat", lg_addr.size(), 32'd2);
        chk("t3_addr0", lg_addr[0], 32'h200);
        chk("t3_be0",   lg_be[0], 32'b1000);
        chk("t3_addr1", lg_addr[1], 32'h204);
        chk("t3_be1",   lg_be[1], 32'b0111);
        chk("t3_fault", {31'h0, cpu_fault}, 32'd0);
        chk("t3_rdata", cpu_rdata, 32'hCCBBDDAA);
`endif
        @(negedge clk);

        // Word-crossing half store
        do_access(1'b1, 32'h0FF, 32'h00001234, 3'b001, 20, cyc);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("t4_cyc",   cyc, 32'd1);
        chk("t4_nbeat", lg_addr.size(), 32'd0);
        chk("t4_fault", {31'h0, cpu_fault}, 32'd1);
`else
        chk("t4_cyc",    cyc, 32'd3);
        chk("t4_nbeat",  lg_addr.size(), 32'd2);
        chk("t4_addr0",  lg_addr[0], 32'h0FC);
        chk("t4_be0",    lg_be[0], 32'b1000);
        chk("t4_wdata0", lg_wdata[0], 32'h34000000);
        chk("t4_we0",    lg_we[0], 32'd1);
        chk("t4_addr1",  lg_addr[1], 32'h100);
        chk("t4_be1",    lg_be[1], 32'b0001);
        chk("t4_wdata1", lg_wdata[1], 32'h00000012);
        chk("t4_rdata",  cpu_rdata, 32'hCCBBDDAA);
`endif
        @(negedge clk);

        // Aligned word store
        do_access(1'b1, 32'h104, 32'hDEADBEEF, 3'b010, 20, cyc);
        chk("t5_cyc",   cyc, 32'd2);
        chk("t5_nbeat", lg_addr.size(), 32'd1);
        chk("t5_addr",  lg_addr[0], 32'h104);
        chk("t5_be",    lg_be[0], 32'b1111);
        chk("t5_wdata", lg_wdata[0], 32'hDEADBEEF);
        chk("t5_we",    lg_we[0], 32'd1);
        @(negedge clk);

`ifndef LSU_MISALIGN_TRAP_EN
        // Crossing the top of the address space wraps to 0
        do_access(1'b0, 32'hFFFFFFFE, 32'h0, 3'b010, 20, cyc);
        chk("t6_cyc",   cyc, 32'd5);
        chk("t6_addr0", lg_addr[0], 32'hFFFFFFFC);
        chk("t6_be0",   lg_be[0], 32'b1100);
        chk("t6_addr1", lg_addr[1], 32'h00000000);
        chk("t6_be1",   lg_be[1], 32'b0011);
        chk("t6_rdata", cpu_rdata, 32'h33445566);
        @(negedge clk);
`endif

        // Size code 11 behaves as word
        mem_arr[8'h40] = 32'h11803344;
        do_access(1'b0, 32'h100, 32'h0, 3'b011, 20, cyc);
        chk("t7_rdata", cpu_rdata, 32'h11803344);
        chk("t7_be",    lg_be[0], 32'b1111);
        @(negedge clk);

        // Timeout with mem_ready held low
        mem_ready = 1'b0;
        @(negedge clk);
        lg_addr.delete();
        cpu_req      = 1'b1;
        cpu_we       = 1'b0;
        cpu_addr     = 32'h108;
        cpu_mem_ctrl = 3'b010;
        cyc  = 0;
        vcnt = 0;
        do begin
            @(negedge clk);
            cpu_req = 1'b0;
            cyc++;
            if (mem_valid && mem_addr == 32'h108 && mem_be == 4'b1111 && !mem_we) vcnt++;
        end while (!cpu_done && cyc < 40);
        chk("t8_done",   {31'h0, cpu_done}, 32'd1);
        chk("t8_cyc",    cyc, 32'd16);
        chk("t8_vcnt",   vcnt, 32'd15);
        chk("t8_fault",  {31'h0, cpu_fault}, 32'd1);
        chk("t8_rdata",  cpu_rdata, 32'h11803344);
        chk("t8_nbeat",  lg_addr.size(), 32'd0);
        @(negedge clk);
        chk("t8_fault_pulse", {31'h0, cpu_fault}, 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);

        // Reset in the middle of W0
        rv_block     = 1'b1;
        cpu_req      = 1'b1;
        cpu_we       = 1'b0;
        cpu_addr     = 32'h100;
        cpu_mem_ctrl = 3'b010;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("t9_b0_valid", {31'h0, mem_valid}, 32'd1);
        @(negedge clk);
        chk("t9_w0_valid", {31'h0, mem_valid}, 32'd0);
        chk("t9_w0_stall", {31'h0, cpu_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t9_rst_stall", {31'h0, cpu_stall}, 32'd0);
        chk("t9_rst_rdata", cpu_rdata, 32'd0);
        chk("t9_rst_be",    {28'h0, mem_be}, 32'd0);
        chk("t9_rst_addr",  mem_addr, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        rv_block = 1'b0;
        @(negedge clk);
        rv_inject = 1'b1;
        @(negedge clk);
        rv_inject = 1'b0;
        @(negedge clk);
        chk("t9_late_done",  {31'h0, cpu_done}, 32'd0);
        chk("t9_late_stall", {31'h0, cpu_stall}, 32'd0);
        @(negedge clk);
        chk("t9_late_done2", {31'h0, cpu_done}, 32'd0);

        // Normal operation after reset
        do_access(1'b0, 32'h102, 32'h0, 3'b000, 20, cyc);
        chk("t10_cyc",   cyc, 32'd3);
        chk("t10_rdata", cpu_rdata, 32'hFFFFFF80);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the execute stage and a word-wide, handshaked data memory port.
- Accepts one access at a time, issues one or two word-aligned memory beats, merges returned words, and returns a sign-/zero-extended load result.
- Stalls the pipeline while busy.
- Byte-lane selection and extension use the same mem_ctrl encoding as the load formatter:
  - [1:0]: 00 = byte, 01 = half, 10 = word.
  - [2]: 1 = unsigned.

Parameters:
- ADDR_W, 32, address width in bits.
- MAX_WAIT, 15, beat-wait cycles before timeout; 0 disables timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_mem_ctrl  in  3  size/sign, encoding above.
- cpu_stall  out  1  high while an access is in flight.
- cpu_done  out  1  one-cycle pulse on completion.
- cpu_rdata  out  32  formatted load result; valid with cpu_done, held until next cpu_done.
- cpu_fault  out  1  pulses with cpu_done on timeout or on a trapped misalignment.
- mem_valid  out  1  beat request.
- mem_ready  in  1  beat accepted when mem_valid && mem_ready.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word-aligned beat address; bits [1:0] = 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-shifted write data.
- mem_rvalid  in  1  read data valid; one per accepted read beat, in order, earliest one cycle after acceptance.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - cpu_stall, cpu_done, cpu_fault, mem_valid, mem_we are 0.
  - mem_be = 0; mem_addr, mem_wdata, cpu_rdata = 0.
  - Reset mid-access abandons the access; late mem_rvalid after reset is ignored.
- Size decode:
  - bytes = 1, 2 or 4; off = cpu_addr[1:0].
  - Split access when off + bytes > 4 (half at off 3; word at off 1..3).
  - cpu_mem_ctrl[1:0] = 11 is treated as word.
- States: IDLE -> B0 -> (W0) -> [B1 -> (W1)] -> DONE -> IDLE.
- IDLE:
  - cpu_stall = 0.
  - On cpu_req: latch all request fields, assert cpu_stall the same cycle (combinational from cpu_req in IDLE), go to B0.
- B0:
  - mem_valid = 1, mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - mem_be = lane mask of bytes shifted left by off, truncated to 4 bits.
  - Store data: mem_wdata = wdata << 8*off.
  - mem_valid, address, be and data stay stable until mem_ready.
  - On accept:
    - Load: go to W0.
    - Store, not split: go to DONE.
    - Store, split: go to B1.
- W0:
  - Wait for mem_rvalid; capture mem_rdata into lo.
  - Go to B1 if split, else DONE.
  - mem_rvalid in the same cycle as acceptance is ignored.
- B1:
  - mem_addr = previous word address + 4; wraps modulo 2^ADDR_W.
  - mem_be = remaining upper lanes.
  - mem_wdata = wdata >> 8*(4-off).
  - On accept: load goes to W1 (capture hi); store goes to DONE.
- DONE (one cycle):
  - cpu_done = 1, cpu_stall = 1.
  - Load result: cpu_rdata = extend(({hi,lo} >> 8*off)[bytes*8-1:0]); signed unless ctrl[2]. hi = 0 if not split.
  - Stores leave cpu_rdata unchanged.
  - Next state is IDLE; a new cpu_req is accepted no earlier than the following cycle.
- Latency, memory with zero wait:
  - Aligned load: 3 cycles, request to cpu_done.
  - Split load: 5 cycles.
  - Aligned store: 2 cycles.
- Timeout:
  - Per-state wait counter counts cycles in B0/W0/B1/W1 without progress.
  - When it reaches MAX_WAIT: go to DONE with cpu_fault = 1, cpu_rdata unchanged, mem_valid dropped.
- cpu_req, cpu_addr and the other request inputs are ignored outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A split access performs no memory beat.
  - Goes IDLE -> DONE, with cpu_done = 1 and cpu_fault = 1 in DONE.
  - cpu_rdata unchanged.
- Undefined: split accesses are performed as two beats as above; cpu_fault only on timeout.

Test Plan:
- Aligned signed byte load:
  - Stimulus: addr 0x102, ctrl 000, memory word 0x11_80_33_44.
  - Response: one beat at 0x100, be 0100, cpu_rdata 0xFFFFFF80, done at cycle 3.
- Unsigned half load:
  - Stimulus: addr 0x102, ctrl 101, memory word 0xBEEF1234.
  - Response: cpu_rdata 0x0000BEEF.
- Split word load:
  - Stimulus: addr 0x203; words 0x200 = 0xAA000000, 0x204 = 0x00CCBBDD.
  - Response: beats at 0x200 (be 1000) then 0x204 (be 0111); cpu_rdata 0xCCBBDDAA; done at cycle 5.
- Split half store:
  - Stimulus: addr 0x0FF, wdata 0x00001234.
  - Response: beat 0x0FC be 1000 wdata 0x34000000; beat 0x100 be 0001 wdata 0x00000012.
- Stall and timeout:
  - Stimulus: mem_ready held 0.
  - Response: mem_valid and fields stable for 15 cycles, then cpu_done + cpu_fault; rst_n pulse mid-W0 returns all outputs to 0 immediately.
- With LSU_MISALIGN_TRAP_EN:
  - Stimulus: word load at 0x001.
  - Response: no mem_valid; cpu_done + cpu_fault one cycle after request.
